vec_check_seq: RTL and testbench
================================

Name: vec_check_seq

Overview:
- Synthesizable vector sequencer and checker for a small combinational block under test (UUT).
- Upstream role: sweeps every input combination onto the UUT inputs.
- Downstream role: samples the UUT's single output, compares it against a parameterised truth table, and reports error count and pass/fail.
- Lets the lab's combinational designs self-test on the board as well as in simulation.

Parameters:
- N_IN, 2: number of UUT inputs. vec_out bit 0 = first input (a), bit 1 = b. Legal range 1..8.
- EXPECTED, 4'b0110: expected truth table, width 2**N_IN. Bit k is the required UUT output when vec_out == k.
- SETTLE_CYCLES, 4: cycles each vector is held before sampling. Must be ≥1.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request to begin a sweep.
- dut_y  in  1  UUT output. Same clock domain; no synchroniser.
- vec_out  out  N_IN  UUT input vector.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; results valid.
- pass  out  1  done with zero errors.
- err_count  out  ERR_W  mismatch count, saturating.
- first_err_vec  out  N_IN  vector index of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a captured value.

Behaviour:
- Reset: while rst_n=0, all outputs are 0 and state is IDLE. Asynchronous; takes effect immediately, including mid-sweep. No partial results are retained.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge → SETTLE.
  - At the same edge: vec_out=0, err_count=0, first_err_valid=0, first_err_vec=0, settle counter=0, busy=1.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles → CHECK. vec_out is held stable.
- CHECK (one cycle):
  - Compare dut_y with EXPECTED[vec_out].
  - On mismatch: err_count += 1, saturating at 2**ERR_W-1. If first_err_valid=0, capture first_err_vec=vec_out and set first_err_valid=1.
  - If vec_out == 2**N_IN-1 → DONE. Otherwise vec_out += 1, counter=0 → SETTLE.
- DONE: busy=0, done=1, pass=(err_count==0). All results hold. start=1 restarts exactly as from IDLE, clearing done and pass at that edge.
- start while busy=1 is ignored.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done rises 2**N_IN*(SETTLE_CYCLES+1) edges after the start edge (20 with defaults).
- The vec_out increment never wraps; the terminal compare occurs before the increment.
- busy and done are never both 1.

Optional Feature:
- Macro: VEC_CHECK_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE after updating the counters. err_count ends at 1 (or saturated 1), pass=0, and vec_out holds the failing vector.
- Undefined: the full sweep always completes, and every mismatch is counted.

Decomposition:
- Package vec_check_pkg holds:
  - the state enum typedef (IDLE, SETTLE, CHECK, DONE);
  - a localparam function giving the counter width, $clog2(SETTLE_CYCLES+1).
- Sub-module sat_counter (parameter W; ports clr, inc, q) implements the saturating err_count. It is reusable by other lab blocks.
- Everything else stays inline in vec_check_seq.

Test Plan (defaults unless noted; the bench supplies a behavioural UUT):
- XOR UUT, start pulse → busy=1 for 20 cycles, then done=1, pass=1, err_count=0, first_err_valid=0. vec_out steps 0,1,2,3, each held 5 cycles.
- AND UUT (table 4'b1000) → err_count=3, first_err_vec=1, first_err_valid=1, pass=0, done after 20 cycles.
- UUT stuck at 1, ERR_W=1 → mismatches at vectors 0 and 3, err_count saturates at 1, first_err_vec=0, pass=0.
- rst_n low at cycle 7 of a sweep → same cycle: vec_out=0, busy=0, err_count=0. After release, the FSM sits in IDLE until start. A second start completes normally in 20 cycles.
- start re-pulsed at cycles 3 and 10 of a sweep → ignored; done still at cycle 20. A start in DONE → done drops next edge and a new 20-cycle sweep runs.
- VEC_CHECK_STOP_ON_ERR_EN defined, AND UUT → done after 10 cycles, err_count=1, vec_out=1, first_err_vec=1, pass=0.

Source files
------------

// File: rtl/vec_check_pkg.sv
// Shared types for the vector sequencer/checker: FSM state encoding and settle-counter sizing.
package vec_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int cnt_w(input int settle_cycles);
      return $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: q updates one edge after clr/inc; no backpressure, holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/vec_check_seq.sv
// Sweeps all UUT input vectors, checks each settled output against EXPECTED; each vector costs
// SETTLE_CYCLES+1 cycles. start is ignored while busy. VEC_CHECK_STOP_ON_ERR_EN: halt at first mismatch.
module vec_check_seq
   import vec_check_pkg::*;
#(
   parameter int                  N_IN          = 2,
   parameter logic [2**N_IN-1:0]  EXPECTED      = 4'b0110,
   parameter int                  SETTLE_CYCLES = 4,
   parameter int                  ERR_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              dut_y,
   output logic [N_IN-1:0]   vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [N_IN-1:0]   first_err_vec,
   output logic              first_err_valid
);

   localparam int              CW       = cnt_w(SETTLE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN-1:0] ferr_q, ferr_d;
   logic            ferr_vld_q, ferr_vld_d;
   logic            err_clr;
   logic            err_inc;
   logic            mism;

   assign mism = dut_y ^ EXPECTED[vec_q];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      ferr_d     = ferr_q;
      ferr_vld_d = ferr_vld_q;
      err_clr    = 1'b0;
      err_inc    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = SETTLE;
               cnt_d      = '0;
               vec_d      = '0;
               ferr_d     = '0;
               ferr_vld_d = 1'b0;
               err_clr    = 1'b1;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (mism) begin
               err_inc = 1'b1;
               if (!ferr_vld_q) begin
                  ferr_d     = vec_q;
                  ferr_vld_d = 1'b1;
               end
            end
            // Terminal test precedes the increment so vec_out never wraps.
            if (vec_q == VEC_LAST) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               cnt_d   = '0;
               state_d = SETTLE;
            end
`ifdef VEC_CHECK_STOP_ON_ERR_EN
            if (mism) begin
               vec_d   = vec_q;
               cnt_d   = cnt_q;
               state_d = DONE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         vec_q      <= '0;
         ferr_q     <= '0;
         ferr_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         ferr_q     <= ferr_d;
         ferr_vld_q <= ferr_vld_d;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (err_clr),
      .inc   (err_inc),
      .q     (err_count)
   );

   assign vec_out         = vec_q;
   assign busy            = (state_q == SETTLE) || (state_q == CHECK);
   assign done            = (state_q == DONE);
   assign pass            = done && (err_count == '0);
   assign first_err_vec   = ferr_q;
   assign first_err_valid = ferr_vld_q;

endmodule

// File: tb/tb_vec_check_seq.sv
// Scoreboard bench for vec_check_seq: two instances (default, ERR_W=1) driving behavioural UUTs.
module tb_vec_check_seq;

   typedef struct {
      int err;
      int fev;
      int fvld;
      int pass;
      int cyc;
      int vec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       and_mode = 1'b0;

   logic [1:0] vec_a, fev_a, vec_b, fev_b;
   logic       busy_a, done_a, pass_a, fvld_a, y_a;
   logic       busy_b, done_b, pass_b, fvld_b, y_b;
   logic [7:0] err_a;
   logic [0:0] err_b;

   int nchk = 0;
   int nbad = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   assign y_a = and_mode ? (vec_a[0] & vec_a[1]) : (vec_a[0] ^ vec_a[1]);
   assign y_b = 1'b1;

   vec_check_seq u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_y(y_a), .vec_out(vec_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_err_vec(fev_a), .first_err_valid(fvld_a)
   );

   vec_check_seq #(.ERR_W(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_y(y_b), .vec_out(vec_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_err_vec(fev_b), .first_err_valid(fvld_b)
   );

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_res(input string tag, input exp_t e, input int err, input int fev,
                          input int fvld, input int pass, input int cyc, input int vec, input int busy);
      check({tag, " err_count"}, err, e.err);
      check({tag, " first_err_vec"}, fev, e.fev);
      check({tag, " first_err_valid"}, fvld, e.fvld);
      check({tag, " pass"}, pass, e.pass);
      check({tag, " cycles"}, cyc, e.cyc);
      check({tag, " vec_out"}, vec, e.vec);
      check({tag, " busy_with_done"}, busy, 0);
   endtask

   // Monitor A: vec_out stepping while busy, result compare on rising done
   int  bcnt_a = 0;
   logic dprev_a = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (busy_a) begin
         check("vec_step_a", int'(vec_a), bcnt_a / 5);
         bcnt_a++;
      end else if (!done_a) begin
         bcnt_a = 0;
      end
      if (done_a && !dprev_a) begin
         if (q_a.size() == 0) begin
            check("sb_a_empty", 1, 0);
         end else begin
            e = q_a.pop_front();
            cmp_res("a", e, int'(err_a), int'(fev_a), int'(fvld_a), int'(pass_a),
                    bcnt_a, int'(vec_a), int'(busy_a));
         end
         bcnt_a = 0;
      end
      dprev_a = done_a;
   end

   int  bcnt_b = 0;
   logic dprev_b = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (busy_b) bcnt_b++;
      else if (!done_b) bcnt_b = 0;
      if (done_b && !dprev_b) begin
         if (q_b.size() == 0) begin
            check("sb_b_empty", 1, 0);
         end else begin
            e = q_b.pop_front();
            cmp_res("b", e, int'(err_b), int'(fev_b), int'(fvld_b), int'(pass_b),
                    bcnt_b, int'(vec_b), int'(busy_b));
         end
         bcnt_b = 0;
      end
      dprev_b = done_b;
   end

   task automatic pulse_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name, input int budget);
      int n = 0;
      while (!done_a && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done_a) check({name, " timeout"}, 0, 1);
      @(negedge clk);
   endtask

   exp_t e_xor, e_and, e_b;

   initial begin
      e_xor = '{err:0, fev:0, fvld:0, pass:1, cyc:20, vec:3};
`ifdef VEC_CHECK_STOP_ON_ERR_EN
      e_and = '{err:1, fev:1, fvld:1, pass:0, cyc:10, vec:1};
      e_b   = '{err:1, fev:0, fvld:1, pass:0, cyc:5,  vec:0};
`else
      e_and = '{err:3, fev:1, fvld:1, pass:0, cyc:20, vec:3};
      e_b   = '{err:1, fev:0, fvld:1, pass:0, cyc:20, vec:3};
`endif
      repeat (2) @(negedge clk);
      check("rst vec_out", int'(vec_a), 0);
      check("rst busy", int'(busy_a), 0);
      check("rst done", int'(done_a), 0);
      check("rst pass", int'(pass_a), 0);
      check("rst err_count", int'(err_a), 0);
      check("rst first_err_valid", int'(fvld_a), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle busy", int'(busy_a), 0);

      // XOR UUT: clean sweep
      and_mode = 1'b0;
      q_a.push_back(e_xor);
      pulse_a();
      wait_done_a("xor", 40);

      // AND UUT, started from DONE: done must drop at the start edge
      and_mode = 1'b1;
      q_a.push_back(e_and);
      pulse_a();
      check("restart done_drop", int'(done_a), 0);
      check("restart busy", int'(busy_a), 1);
      wait_done_a("and", 40);

      // start re-pulsed mid-sweep must be ignored
      and_mode = 1'b0;
      q_a.push_back(e_xor);
      pulse_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (6) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      wait_done_a("repulse", 40);

      // asynchronous reset mid-sweep
      q_a.push_back(e_xor);
      pulse_a();
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst vec_out", int'(vec_a), 0);
      check("arst busy", int'(busy_a), 0);
      check("arst err_count", int'(err_a), 0);
      check("arst done", int'(done_a), 0);
      void'(q_a.pop_back());
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst idle busy", int'(busy_a), 0);
      check("post_rst idle done", int'(done_a), 0);
      q_a.push_back(e_xor);
      pulse_a();
      wait_done_a("post_rst", 40);

      // stuck-at-1 UUT with 1-bit saturating error counter
      q_b.push_back(e_b);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      begin
         int n = 0;
         while (!done_b && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (!done_b) check("b timeout", 0, 1);
      end
      @(negedge clk);
      check("sb_a drained", q_a.size(), 0);
      check("sb_b drained", q_b.size(), 0);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
